conv_buffer_ctrl: RTL and testbench

- Sequencer for the 3x3 sliding-window line buffer feeding the TI-channel PE array.
- Loads TI weight kernels first, then preloads three input rows.
- Then issues window-read beats (one per channel, per output position) and refills one input row at the end of each output row, until the whole layer is processed.
- Sits between the upstream weight/activation sources (valid/ready) and the buffer's weight_fire / data_fire / done strobes.

---
 rtl/conv_buffer_ctrl_if.sv | 32 +++
 rtl/conv_buffer_ctrl.sv | 135 +++++++++++++
 tb/tb_conv_buffer_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_buffer_ctrl_if.sv
// Handshake and status bundle between the line-buffer sequencer and its neighbours.
// The slave modport is the controller; the master modport is the upstream/PE side.
interface conv_buffer_ctrl_if #(
    parameter int CNT_BITS = 9
);
    logic                start;
    logic                w_valid;
    logic                w_ready;
    logic                d_valid;
    logic                d_ready;
    logic                pe_ready;
    logic                buffer_weight_fire;
    logic                buffer_data_fire;
    logic                buffer_done;
    logic [4:0]          chan_idx;
    logic [CNT_BITS-1:0] out_row;
    logic [CNT_BITS-1:0] out_col;
    logic                busy;
    logic                layer_done;

    modport slave (
        input  start, w_valid, d_valid, pe_ready,
        output w_ready, d_ready, buffer_weight_fire, buffer_data_fire, buffer_done,
               chan_idx, out_row, out_col, busy, layer_done
    );

    modport master (
        output start, w_valid, d_valid, pe_ready,
        input  w_ready, d_ready, buffer_weight_fire, buffer_data_fire, buffer_done,
               chan_idx, out_row, out_col, busy, layer_done
    );
endinterface

// File: rtl/conv_buffer_ctrl.sv
// Sequencer for the 3x3 sliding-window line buffer: weight load, three-row preload,
// per-channel window beats, and one row refill at the end of every output row.
module conv_buffer_ctrl #(
    parameter int TI         = 3,
    parameter int INPUT_SIZE = 16,
    parameter int KSIZE      = 3,
    parameter int CNT_BITS   = 9
) (
    input  logic               clk,
    input  logic               rst,
    conv_buffer_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_D, COMPUTE, REFILL} state_t;

    localparam logic [4:0]          CHAN_LAST = 5'(TI - 1);
    localparam logic [CNT_BITS-1:0] W_LAST    = CNT_BITS'(TI - 1);
    localparam logic [CNT_BITS-1:0] PRE_LAST  = CNT_BITS'(3 * INPUT_SIZE - 1);
    localparam logic [CNT_BITS-1:0] ROW_LAST  = CNT_BITS'(INPUT_SIZE - 1);
    localparam logic [CNT_BITS-1:0] POS_LAST  = CNT_BITS'(INPUT_SIZE - KSIZE);

    state_t              state, state_nx;
    logic [CNT_BITS-1:0] load_cnt, load_cnt_nx;
    logic [CNT_BITS-1:0] out_row, out_row_nx;
    logic [CNT_BITS-1:0] out_col, out_col_nx;
    logic [4:0]          chan, chan_nx;
    logic                w_ready, d_ready, w_fire, d_fire, beat, last_beat;

    // Readies decode straight from the registered state, so they never glitch on inputs.
    assign w_ready   = (state == LOAD_W);
    assign d_ready   = (state == LOAD_D) || (state == REFILL);
    assign w_fire    = w_ready & bus.w_valid;
    assign d_fire    = d_ready & bus.d_valid;
    assign beat      = (state == COMPUTE) & bus.pe_ready;
    assign last_beat = beat && (chan == CHAN_LAST) && (out_col == POS_LAST)
                       && (out_row == POS_LAST);

    assign bus.w_ready            = w_ready;
    assign bus.d_ready            = d_ready;
    assign bus.buffer_weight_fire = w_fire;
    assign bus.buffer_data_fire   = d_fire;
    assign bus.buffer_done        = beat;
    assign bus.chan_idx           = chan;
    assign bus.out_row            = out_row;
    assign bus.out_col            = out_col;
    assign bus.busy               = (state != IDLE);
    assign bus.layer_done         = last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            load_cnt <= '0;
            out_row  <= '0;
            out_col  <= '0;
            chan     <= '0;
        end else begin
            state    <= state_nx;
            load_cnt <= load_cnt_nx;
            out_row  <= out_row_nx;
            out_col  <= out_col_nx;
            chan     <= chan_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        load_cnt_nx = load_cnt;
        out_row_nx  = out_row;
        out_col_nx  = out_col;
        chan_nx     = chan;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx    = LOAD_W;
                    load_cnt_nx = '0;
                    out_row_nx  = '0;
                    out_col_nx  = '0;
                    chan_nx     = '0;
                end
            end
            LOAD_W: begin
                if (w_fire) begin
                    if (load_cnt == W_LAST) begin
                        load_cnt_nx = '0;
                        state_nx    = LOAD_D;
                    end else begin
                        load_cnt_nx = load_cnt + 1'b1;
                    end
                end
            end
            LOAD_D: begin
                if (d_fire) begin
                    if (load_cnt == PRE_LAST) begin
                        load_cnt_nx = '0;
                        state_nx    = COMPUTE;
                    end else begin
                        load_cnt_nx = load_cnt + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                // Channel is the fastest index, then column, then row.
                if (beat) begin
                    if (chan == CHAN_LAST) begin
                        chan_nx = '0;
                        if (out_col == POS_LAST) begin
                            out_col_nx = '0;
                            if (out_row == POS_LAST) begin
                                out_row_nx = '0;
                                state_nx   = IDLE;
                            end else begin
                                out_row_nx = out_row + 1'b1;
                                state_nx   = REFILL;
                            end
                        end else begin
                            out_col_nx = out_col + 1'b1;
                        end
                    end else begin
                        chan_nx = chan + 1'b1;
                    end
                end
            end
            REFILL: begin
                if (d_fire) begin
                    if (load_cnt == ROW_LAST) begin
                        load_cnt_nx = '0;
                        state_nx    = COMPUTE;
                    end else begin
                        load_cnt_nx = load_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_conv_buffer_ctrl.sv
// Self-checking bench for conv_buffer_ctrl; a negedge scoreboard derives the legal
// order of weight fires, data fires and window beats from layer geometry alone.
module tb_conv_buffer_ctrl;
    localparam int TI    = 3;
    localparam int N     = 4;
    localparam int CB    = 9;
    localparam int NP    = N - 2;
    localparam int TOTAL = TI * NP * NP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_buffer_ctrl_if #(.CNT_BITS(CB)) bus ();

    conv_buffer_ctrl #(.TI(TI), .INPUT_SIZE(N), .KSIZE(3), .CNT_BITS(CB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int wcnt, dcnt, bcnt, refill_cnt, ld_cnt, ld_beat;
    bit prev_ld;

    // Scoreboard: every fire and beat must fall at the position the layer geometry allows.
    always @(negedge clk) begin
        int exp_b, exp_ch, exp_row, exp_col, pos;
        checks++;
        if ($countones({bus.w_ready, bus.d_ready, bus.buffer_done}) > 1) begin
            errors++;
            $display("[TB] FAIL exclusive: w_ready=%b d_ready=%b done=%b, need at most one", bus.w_ready, bus.d_ready, bus.buffer_done);
        end
        checks++;
        if (bus.buffer_weight_fire !== (bus.w_valid & bus.w_ready) || bus.buffer_data_fire !== (bus.d_valid & bus.d_ready)) begin
            errors++;
            $display("[TB] FAIL fire_def: wfire=%b dfire=%b, need %b %b", bus.buffer_weight_fire, bus.buffer_data_fire, bus.w_valid & bus.w_ready, bus.d_valid & bus.d_ready);
        end
        if (prev_ld) begin
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_after_done: busy=%b, need 0", bus.busy);
            end
        end
        prev_ld = (bus.layer_done === 1'b1);
        if (bus.buffer_weight_fire === 1'b1) begin
            checks++;
            if (wcnt >= TI || dcnt != 0 || bcnt != 0) begin
                errors++;
                $display("[TB] FAIL weight_place: w=%0d d=%0d b=%0d, need w<%0d d=0 b=0", wcnt, dcnt, bcnt, TI);
            end
            wcnt++;
        end
        if (bus.buffer_data_fire === 1'b1) begin
            exp_b = (dcnt < 3 * N) ? 0 : ((dcnt - 3 * N) / N + 1) * TI * NP;
            checks++;
            if (dcnt >= N * N || wcnt != TI || bcnt != exp_b) begin
                errors++;
                $display("[TB] FAIL data_place: d=%0d w=%0d b=%0d, need d<%0d w=%0d b=%0d", dcnt, wcnt, bcnt, N * N, TI, exp_b);
            end
            if (bcnt > 0) refill_cnt++;
            dcnt++;
        end
        checks++;
        if (bus.layer_done !== ((bus.buffer_done === 1'b1) && bcnt == TOTAL - 1)) begin
            errors++;
            $display("[TB] FAIL layer_done: got %b at beat index %0d, need pulse only at %0d", bus.layer_done, bcnt, TOTAL - 1);
        end
        if (bus.buffer_done === 1'b1) begin
            exp_ch  = bcnt % TI;
            pos     = bcnt / TI;
            exp_row = pos / NP;
            exp_col = pos % NP;
            checks++;
            if (bcnt >= TOTAL || int'(bus.chan_idx) != exp_ch || int'(bus.out_row) != exp_row
                || int'(bus.out_col) != exp_col || dcnt != 3 * N + exp_row * N || wcnt != TI) begin
                errors++;
                $display("[TB] FAIL beat: idx=%0d ch/row/col=%0d/%0d/%0d d=%0d, need %0d/%0d/%0d d=%0d", bcnt, bus.chan_idx, bus.out_row, bus.out_col, dcnt, exp_ch, exp_row, exp_col, 3 * N + exp_row * N);
            end
            if (bus.layer_done === 1'b1) begin
                ld_cnt++;
                ld_beat = bcnt + 1;
            end
            bcnt++;
        end
        if (rst === 1'b1 || (bus.start === 1'b1 && bus.busy === 1'b0)) begin
            wcnt = 0; dcnt = 0; bcnt = 0; refill_cnt = 0; ld_cnt = 0; ld_beat = 0; prev_ld = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int mode);
        if (mode == 0) begin
            bus.w_valid = 1'b1; bus.d_valid = 1'b1; bus.pe_ready = 1'b1;
        end else begin
            bus.w_valid  = ($urandom_range(0, 3) != 0);
            bus.d_valid  = ($urandom_range(0, 3) != 0);
            bus.pe_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic pulse_start();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_layer(input int mode, output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive(mode);
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1);
            @(negedge clk);
            checks++;
            if ({bus.w_ready, bus.d_ready, bus.buffer_weight_fire, bus.buffer_data_fire, bus.buffer_done,
                 bus.chan_idx, bus.out_row, bus.out_col, bus.busy, bus.layer_done} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_idle: cycle %0d busy=%b ch=%0d row=%0d col=%0d, need all 0", i, bus.busy, bus.chan_idx, bus.out_row, bus.out_col);
            end
            tick();
        end
    endtask

    task automatic test_weight_gaps();
        bit [3:0] pat = 4'b1101;
        int nf = 0;
        bit to;
        tick();
        bus.start = 1'b1;
        drive(0);
        @(negedge clk);
        checks++;
        if ({bus.w_ready, bus.d_ready, bus.buffer_done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL start_latency: w_ready/d_ready/done=%b%b%b, need 000", bus.w_ready, bus.d_ready, bus.buffer_done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.start = 1'b0;
            bus.w_valid = pat[i];
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (bus.w_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL first_w_ready: got %b, need 1", bus.w_ready);
                end
            end
            if (bus.buffer_weight_fire === 1'b1) nf++;
        end
        checks++;
        if (nf != 3) begin
            errors++;
            $display("[TB] FAIL weight_fires: got %0d, need 3", nf);
        end
        tick();
        bus.w_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.d_ready !== 1'b1 || bus.w_ready !== 1'b0 || bus.buffer_weight_fire !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_load_d: d_ready=%b w_ready=%b wfire=%b, need 1 0 0", bus.d_ready, bus.w_ready, bus.buffer_weight_fire);
        end
        tick();
        run_layer(1, to);
        checks++;
        if (to || wcnt != TI || dcnt != N * N || bcnt != TOTAL) begin
            errors++;
            $display("[TB] FAIL gaps_totals: to=%b w=%0d d=%0d b=%0d, need 0 %0d %0d %0d", to, wcnt, dcnt, bcnt, TI, N * N, TOTAL);
        end
    endtask

    task automatic test_full_layer();
        bit to;
        pulse_start();
        run_layer(0, to);
        checks++;
        if (to || wcnt != TI || dcnt != N * N || bcnt != TOTAL) begin
            errors++;
            $display("[TB] FAIL full_totals: to=%b w=%0d d=%0d b=%0d, need 0 %0d %0d %0d", to, wcnt, dcnt, bcnt, TI, N * N, TOTAL);
        end
        checks++;
        if (refill_cnt != N * (NP - 1)) begin
            errors++;
            $display("[TB] FAIL refill_fires: got %0d, need %0d", refill_cnt, N * (NP - 1));
        end
        checks++;
        if (ld_cnt != 1 || ld_beat != TOTAL) begin
            errors++;
            $display("[TB] FAIL done_beat: pulses=%0d on beat %0d, need 1 on beat %0d", ld_cnt, ld_beat, TOTAL);
        end
    endtask

    task automatic test_pe_stall();
        int nb = 0;
        bit found = 0, to;
        pulse_start();
        for (int i = 0; i < 200 && !found; i++) begin
            drive(0);
            @(negedge clk);
            if (bus.buffer_done === 1'b1) nb++;
            if (nb == TI + 1) found = 1;
            tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL stall_reach: beats seen %0d, need %0d", nb, TI + 1);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0);
            bus.pe_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.buffer_done !== 1'b0 || int'(bus.chan_idx) != 1 || int'(bus.out_row) != 0 || int'(bus.out_col) != 1) begin
                errors++;
                $display("[TB] FAIL stall_hold: done=%b ch/row/col=%0d/%0d/%0d, need 0 1/0/1", bus.buffer_done, bus.chan_idx, bus.out_row, bus.out_col);
            end
            tick();
        end
        run_layer(0, to);
        checks++;
        if (to || bcnt != TOTAL || ld_cnt != 1) begin
            errors++;
            $display("[TB] FAIL stall_totals: to=%b b=%0d done=%0d, need 0 %0d 1", to, bcnt, ld_cnt, TOTAL);
        end
    endtask

    task automatic test_start_busy();
        int nb = 0;
        bit to;
        pulse_start();
        for (int i = 0; i < 200 && nb < 5; i++) begin
            drive(0);
            @(negedge clk);
            if (bus.buffer_done === 1'b1) nb++;
            tick();
        end
        bus.start = 1'b1;
        drive(0);
        @(negedge clk);
        tick();
        bus.start = 1'b0;
        run_layer(0, to);
        checks++;
        if (to || wcnt != TI || dcnt != N * N || bcnt != TOTAL || ld_cnt != 1) begin
            errors++;
            $display("[TB] FAIL start_busy: to=%b w=%0d d=%0d b=%0d done=%0d, need 0 %0d %0d %0d 1", to, wcnt, dcnt, bcnt, ld_cnt, TI, N * N, TOTAL);
        end
    endtask

    task automatic test_reset_refill();
        int nb = 0, nr = 0;
        bit to;
        pulse_start();
        for (int i = 0; i < 200 && nr < 2; i++) begin
            drive(0);
            @(negedge clk);
            if (bus.buffer_done === 1'b1) nb++;
            if (nb > 0 && bus.buffer_data_fire === 1'b1) nr++;
            tick();
        end
        rst = 1'b1;
        bus.w_valid = 1'b0; bus.d_valid = 1'b0; bus.pe_ready = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        drive(0);
        @(negedge clk);
        checks++;
        if ({bus.w_ready, bus.d_ready, bus.buffer_weight_fire, bus.buffer_data_fire, bus.buffer_done,
             bus.chan_idx, bus.out_row, bus.out_col, bus.busy, bus.layer_done} !== '0 || nr != 2) begin
            errors++;
            $display("[TB] FAIL reset_refill: refill=%0d busy=%b d_ready=%b ch/row/col=%0d/%0d/%0d, need 2 and all 0", nr, bus.busy, bus.d_ready, bus.chan_idx, bus.out_row, bus.out_col);
        end
        pulse_start();
        run_layer(1, to);
        checks++;
        if (to || wcnt != TI || dcnt != N * N || bcnt != TOTAL || ld_cnt != 1) begin
            errors++;
            $display("[TB] FAIL after_reset: to=%b w=%0d d=%0d b=%0d done=%0d, need 0 %0d %0d %0d 1", to, wcnt, dcnt, bcnt, ld_cnt, TI, N * N, TOTAL);
        end
    endtask

    task automatic test_random_layers();
        bit to;
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            run_layer(1, to);
            checks++;
            if (to || wcnt != TI || dcnt != N * N || bcnt != TOTAL || ld_cnt != 1) begin
                errors++;
                $display("[TB] FAIL random_layer%0d: to=%b w=%0d d=%0d b=%0d done=%0d, need 0 %0d %0d %0d 1", k, to, wcnt, dcnt, bcnt, ld_cnt, TI, N * N, TOTAL);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.w_valid = 1'b0; bus.d_valid = 1'b0; bus.pe_ready = 1'b0;
        test_reset();
        test_weight_gaps();
        test_full_layer();
        test_pe_stall();
        test_start_busy();
        test_reset_refill();
        test_random_layers();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
